// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default sizing, also used by the PWM generator.
package pwm_pkg;

  localparam int DEFAULT_BITS        = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input into the clk domain and flags its rising and falling edges.
module sync_edge_det
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  // Shift the raw input through the synchronizer chain, then keep one extra copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~s_d_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in clk cycles.
// A period that reaches the counter ceiling without a new rise sets a sticky timeout instead.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int BITS        = DEFAULT_BITS,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            pwm_in,
  output logic [BITS-1:0] high_cnt,
  output logic [BITS-1:0] period_cnt,
  output logic            valid,
  output logic            timeout,
  output logic            level
);

  // The period counter may never reach all-ones; hitting it from CNT_LAST means no rise arrived in time.
  localparam logic [BITS-1:0] CNT_ZERO = '0;
  localparam logic [BITS-1:0] CNT_ONE  = BITS'(1);
  localparam logic [BITS-1:0] CNT_SAT  = '1;
  localparam logic [BITS-1:0] CNT_LAST = CNT_SAT - CNT_ONE;

  logic s;
  logic rise;
  logic fall;

  pwm_state_e      state_q;
  logic [BITS-1:0] p_q;
  logic [BITS-1:0] h_q;
  logic [BITS-1:0] p_d;
  logic [BITS-1:0] h_d;
  logic [BITS-1:0] high_q;
  logic [BITS-1:0] period_q;
  logic            valid_q;
  logic            timeout_q;
  logic            level_q;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .d_i   (pwm_in),
    .s_o   (s),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign p_d = p_q + CNT_ONE;
  assign h_d = h_q + CNT_ONE;

  // Capture FSM: counts the current period, publishes it on the closing rise, and handles timeout/enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      p_q       <= CNT_ZERO;
      h_q       <= CNT_ZERO;
      high_q    <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      level_q <= s;
      if (!en) begin
        state_q   <= IDLE;
        p_q       <= CNT_ZERO;
        h_q       <= CNT_ZERO;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            p_q     <= CNT_ZERO;
            h_q     <= CNT_ZERO;
            state_q <= ARM;
          end
          ARM: begin
            if (rise) begin
              p_q     <= CNT_ONE;
              h_q     <= CNT_ONE;
              state_q <= HIGH;
            end else if (p_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              p_q       <= CNT_ZERO;
              h_q       <= CNT_ZERO;
              state_q   <= ARM;
            end else begin
              p_q <= p_d;
            end
          end
          HIGH: begin
            if (p_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              p_q       <= CNT_ZERO;
              h_q       <= CNT_ZERO;
              state_q   <= ARM;
            end else begin
              p_q <= p_d;
              if (s) begin
                h_q <= h_d;
              end
              if (fall) begin
                state_q <= LOW;
              end
            end
          end
          LOW: begin
            if (rise) begin
              high_q    <= h_q;
              period_q  <= p_q;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              p_q       <= CNT_ONE;
              h_q       <= CNT_ONE;
              state_q   <= HIGH;
            end else if (p_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              p_q       <= CNT_ZERO;
              h_q       <= CNT_ZERO;
              state_q   <= ARM;
            end else begin
              p_q <= p_d;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a 16-bit and a 4-bit instance watch the same PWM waveform.
// Expected measurements come from the high/low widths the bench itself chose to drive.
module tb_pwm_capture;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        pwm;
  logic [15:0] h16, p16;
  logic        v16, t16, l16;
  logic [3:0]  h4, p4;
  logic        v4, t4, l4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int h; int p; int t;} obs_t;
  typedef struct {int h; int p;} meas_t;

  obs_t q16[$];
  obs_t q4[$];

  pwm_capture #(.BITS(16), .SYNC_STAGES(SS)) dut16 (
    .clk(clk), .rstn(rstn), .en(en), .pwm_in(pwm),
    .high_cnt(h16), .period_cnt(p16), .valid(v16), .timeout(t16), .level(l16)
  );

  pwm_capture #(.BITS(4), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rstn(rstn), .en(en), .pwm_in(pwm),
    .high_cnt(h4), .period_cnt(p4), .valid(v4), .timeout(t4), .level(l4)
  );

  // Free-running clock and cycle counter used to timestamp valid pulses.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse from both instances, sampled away from the active edge.
  always @(negedge clk) begin
    if (v16 === 1'b1) q16.push_back('{int'(h16), int'(p16), cyc});
    if (v4 === 1'b1) q4.push_back('{int'(h4), int'(p4), cyc});
  end

  // Hard stop in case something stalls.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic resetDut();
    rstn = 1'b0;
    en   = 1'b0;
    pwm  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    q16.delete();
    q4.delete();
  endtask

  task automatic drivePeriod(input int hi, input int lo);
    pwm = 1'b1;
    repeat (hi) @(negedge clk);
    pwm = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // A closing rise publishes the last complete period; pwm then drops and stays low.
  task automatic closeRise();
    pwm = 1'b1;
    repeat (SS + 3) @(negedge clk);
    pwm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    pwm  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({h16, p16, v16, t16, l16} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset16 got h=%0d p=%0d v=%b t=%b l=%b want all 0", h16, p16, v16, t16, l16);
    end
    checks++;
    if ({h4, p4, v4, t4, l4} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset4 got h=%0d p=%0d v=%b t=%b l=%b want all 0", h4, p4, v4, t4, l4);
    end
    pwm  = 1'b0;
    rstn = 1'b1;
    en   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_3_7();
    resetDut();
    en = 1'b1;
    repeat (3) @(negedge clk);
    repeat (5) drivePeriod(3, 7);
    closeRise();
    checks++;
    if (q16.size() != 5) begin
      errors++;
      $display("[TB] FAIL basic_count16 got %0d want %0d", q16.size(), 5);
    end
    for (int i = 0; i < q16.size() && i < 5; i++) begin
      checks++;
      if (q16[i].h != 3 || q16[i].p != 10) begin
        errors++;
        $display("[TB] FAIL basic_meas16[%0d] got h=%0d p=%0d want h=3 p=10", i, q16[i].h, q16[i].p);
      end
      if (i > 0) begin
        checks++;
        if (q16[i].t - q16[i-1].t != 10) begin
          errors++;
          $display("[TB] FAIL basic_gap16[%0d] got %0d want 10", i, q16[i].t - q16[i-1].t);
        end
      end
    end
    checks++;
    if (q4.size() != 5) begin
      errors++;
      $display("[TB] FAIL basic_count4 got %0d want %0d", q4.size(), 5);
    end
    for (int i = 0; i < q4.size() && i < 5; i++) begin
      checks++;
      if (q4[i].h != 3 || q4[i].p != 10) begin
        errors++;
        $display("[TB] FAIL basic_meas4[%0d] got h=%0d p=%0d want h=3 p=10", i, q4[i].h, q4[i].p);
      end
    end
  endtask

  task automatic test_latency();
    int n;
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    drivePeriod(2, 3);
    pwm = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (v16 === 1'b1) break;
    end
    checks++;
    if (n != SS + 1) begin
      errors++;
      $display("[TB] FAIL latency got %0d cycles want %0d", n, SS + 1);
    end
    checks++;
    if (h16 !== 16'd2 || p16 !== 16'd5) begin
      errors++;
      $display("[TB] FAIL latency_meas got h=%0d p=%0d want h=2 p=5", h16, p16);
    end
    @(negedge clk);
    checks++;
    if (v16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL valid_width got v=%b want 0 one cycle after pulse", v16);
    end
    pwm = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_min_period();
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (8) drivePeriod(1, 1);
    closeRise();
    checks++;
    if (q16.size() != 8) begin
      errors++;
      $display("[TB] FAIL min_count got %0d want %0d", q16.size(), 8);
    end
    for (int i = 0; i < q16.size() && i < 8; i++) begin
      checks++;
      if (q16[i].h != 1 || q16[i].p != 2) begin
        errors++;
        $display("[TB] FAIL min_meas[%0d] got h=%0d p=%0d want h=1 p=2", i, q16[i].h, q16[i].p);
      end
      if (i > 0) begin
        checks++;
        if (q16[i].t - q16[i-1].t != 2) begin
          errors++;
          $display("[TB] FAIL min_gap[%0d] got %0d want 2", i, q16[i].t - q16[i-1].t);
        end
      end
    end
  endtask

  task automatic test_random_periods();
    meas_t expq[$];
    int hi;
    int lo;
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 6);
      expq.push_back('{hi, hi + lo});
      drivePeriod(hi, lo);
    end
    closeRise();
    checks++;
    if (q16.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL rand_count16 got %0d want %0d", q16.size(), expq.size());
    end
    checks++;
    if (q4.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL rand_count4 got %0d want %0d", q4.size(), expq.size());
    end
    for (int i = 0; i < q16.size() && i < expq.size(); i++) begin
      checks++;
      if (q16[i].h != expq[i].h || q16[i].p != expq[i].p) begin
        errors++;
        $display("[TB] FAIL rand_meas16[%0d] got h=%0d p=%0d want h=%0d p=%0d",
                 i, q16[i].h, q16[i].p, expq[i].h, expq[i].p);
      end
      if (i > 0) begin
        checks++;
        if (q16[i].t - q16[i-1].t != expq[i].p) begin
          errors++;
          $display("[TB] FAIL rand_gap[%0d] got %0d want %0d", i, q16[i].t - q16[i-1].t, expq[i].p);
        end
      end
    end
    for (int i = 0; i < q4.size() && i < expq.size(); i++) begin
      checks++;
      if (q4[i].h != expq[i].h || q4[i].p != expq[i].p) begin
        errors++;
        $display("[TB] FAIL rand_meas4[%0d] got h=%0d p=%0d want h=%0d p=%0d",
                 i, q4[i].h, q4[i].p, expq[i].h, expq[i].p);
      end
    end
  endtask

  task automatic test_saturation_boundary();
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (3) drivePeriod(7, 7);
    pwm = 1'b1;
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (t4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rise_beats_sat timeout got %b want 0", t4);
    end
    checks++;
    if (q4.size() != 3) begin
      errors++;
      $display("[TB] FAIL sat14_count4 got %0d want 3", q4.size());
    end
    repeat (7 - (SS + 3)) @(negedge clk);
    pwm = 1'b0;
    repeat (8) @(negedge clk);
    repeat (2) drivePeriod(7, 8);
    closeRise();
    checks++;
    if (q4.size() != 3) begin
      errors++;
      $display("[TB] FAIL sat15_count4 got %0d want 3", q4.size());
    end
    for (int i = 0; i < q4.size() && i < 3; i++) begin
      checks++;
      if (q4[i].h != 7 || q4[i].p != 14) begin
        errors++;
        $display("[TB] FAIL sat_meas4[%0d] got h=%0d p=%0d want h=7 p=14", i, q4[i].h, q4[i].p);
      end
    end
    checks++;
    if (t4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_timeout4 got %b want 1", t4);
    end
    checks++;
    if (q16.size() != 6) begin
      errors++;
      $display("[TB] FAIL sat_count16 got %0d want 6", q16.size());
    end
    for (int i = 0; i < q16.size() && i < 6; i++) begin
      checks++;
      if (q16[i].h != 7 || q16[i].p != (i < 3 ? 14 : 15)) begin
        errors++;
        $display("[TB] FAIL sat_meas16[%0d] got h=%0d p=%0d want h=7 p=%0d",
                 i, q16[i].h, q16[i].p, (i < 3 ? 14 : 15));
      end
    end
  endtask

  task automatic test_timeout_stuck();
    int n;
    resetDut();
    en = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (t4 === 1'b1) break;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("[TB] FAIL stuck0_time got %0d cycles want 16", n);
    end
    checks++;
    if (l4 !== 1'b0 || q4.size() != 0) begin
      errors++;
      $display("[TB] FAIL stuck0_level got l=%b valids=%0d want l=0 valids=0", l4, q4.size());
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (t4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_clears_timeout got %b want 0", t4);
    end
    en  = 1'b1;
    pwm = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (t4 !== 1'b1 || l4 !== 1'b1 || q4.size() != 0) begin
      errors++;
      $display("[TB] FAIL stuck1 got t=%b l=%b valids=%0d want t=1 l=1 valids=0", t4, l4, q4.size());
    end
    pwm = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4) drivePeriod(2, 2);
    closeRise();
    checks++;
    if (q4.size() != 4) begin
      errors++;
      $display("[TB] FAIL recover_count got %0d want 4", q4.size());
    end
    for (int i = 0; i < q4.size() && i < 4; i++) begin
      checks++;
      if (q4[i].h != 2 || q4[i].p != 4) begin
        errors++;
        $display("[TB] FAIL recover_meas[%0d] got h=%0d p=%0d want h=2 p=4", i, q4[i].h, q4[i].p);
      end
    end
    checks++;
    if (t4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL recover_timeout got %b want 0", t4);
    end
  endtask

  task automatic test_enable_drop();
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (2) drivePeriod(4, 6);
    pwm = 1'b1;
    repeat (SS + 2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (h16 !== 16'd4 || p16 !== 16'd10 || v16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_hold got h=%0d p=%0d v=%b want h=4 p=10 v=0", h16, p16, v16);
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) drivePeriod(5, 5);
    closeRise();
    checks++;
    if (q16.size() != 4) begin
      errors++;
      $display("[TB] FAIL en_count got %0d want 4", q16.size());
    end
    for (int i = 0; i < q16.size() && i < 4; i++) begin
      checks++;
      if (q16[i].h != (i < 2 ? 4 : 5) || q16[i].p != 10) begin
        errors++;
        $display("[TB] FAIL en_meas[%0d] got h=%0d p=%0d want h=%0d p=10",
                 i, q16[i].h, q16[i].p, (i < 2 ? 4 : 5));
      end
    end
  endtask

  task automatic test_reset_mid_low();
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (2) drivePeriod(3, 7);
    pwm = 1'b1;
    repeat (3) @(negedge clk);
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (h16 !== 16'd3 || p16 !== 16'd10) begin
      errors++;
      $display("[TB] FAIL pre_reset got h=%0d p=%0d want h=3 p=10", h16, p16);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({h16, p16, v16, t16, l16} !== 35'd0 || {h4, p4, v4, t4, l4} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midlow_reset got h=%0d p=%0d h4=%0d p4=%0d want all 0", h16, p16, h4, p4);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    q16.delete();
    repeat (2) drivePeriod(3, 7);
    closeRise();
    checks++;
    if (q16.size() != 2) begin
      errors++;
      $display("[TB] FAIL post_reset_count got %0d want 2", q16.size());
    end
    for (int i = 0; i < q16.size() && i < 2; i++) begin
      checks++;
      if (q16[i].h != 3 || q16[i].p != 10) begin
        errors++;
        $display("[TB] FAIL post_reset_meas[%0d] got h=%0d p=%0d want h=3 p=10", i, q16[i].h, q16[i].p);
      end
    end
  endtask

  // Behavioural 4-bit PWM generator, one count per clock: high while the count is below the duty value.
  task automatic test_generator();
    int duty;
    duty = 5;
    resetDut();
    en = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k <= 80; k++) begin
      pwm = ((k % 16) < duty);
      @(negedge clk);
    end
    repeat (SS + 3) @(negedge clk);
    pwm = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (q16.size() != 5) begin
      errors++;
      $display("[TB] FAIL gen_count got %0d want 5", q16.size());
    end
    for (int i = 0; i < q16.size() && i < 5; i++) begin
      checks++;
      if (q16[i].h != duty || q16[i].p != 16 || q16[i].h * 16 != q16[i].p * duty) begin
        errors++;
        $display("[TB] FAIL gen_meas[%0d] got h=%0d p=%0d want h=%0d p=16", i, q16[i].h, q16[i].p, duty);
      end
    end
    checks++;
    if (q4.size() != 0 || t4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gen_narrow got valids=%0d t=%b want valids=0 t=1", q4.size(), t4);
    end
  endtask

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    pwm  = 1'b0;
    test_reset();
    test_basic_3_7();
    test_latency();
    test_min_period();
    test_random_periods();
    test_saturation_boundary();
    test_timeout_stuck();
    test_enable_drop();
    test_reset_mid_low();
    test_generator();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: BITS, 16, width of all measurement counters and outputs (range 4..32).
REQ-002 Parameter: SYNC_STAGES, 2, number of input synchronizer flops (range 2..4).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous and active-low.
REQ-005 Port: en  input  1  capture enable; low forces IDLE.
REQ-006 Port: pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-007 Port: high_cnt  output  BITS  clk cycles the input was high in the last complete period.
REQ-008 Port: period_cnt  output  BITS  clk cycles in the last complete period, rise to rise.
REQ-009 Port: valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
REQ-010 Port: timeout  output  1  sticky flag, no rising edge within 2^BITS-1 cycles.
REQ-011 Port: level  output  1  synchronized level of pwm_in, meaningful when timeout=1 (stuck-at value).

Function
REQ-012 pwm_in shall pass through SYNC_STAGES flops to give s, plus one delay flop s_d; rise = s & ~s_d, fall = ~s & s_d.
REQ-013 FSM states: IDLE, ARM, HIGH, LOW.
REQ-014 IDLE: counters cleared; go to ARM when en=1.
REQ-015 ARM: wait for first rise; no measurement issued; on rise load p=1, h=1, go to HIGH.
REQ-016 HIGH: each cycle p+=1; h+=1 while s=1; on fall go to LOW.
REQ-017 LOW: each cycle p+=1; on rise latch high_cnt=h, period_cnt=p, pulse valid, reload p=1, h=1, go to HIGH.
REQ-018 Outputs shall update on the clock edge that samples rise; valid shall be high exactly that following cycle; latency pin->valid = SYNC_STAGES+1 cycles after the pwm_in rising edge.
REQ-019 high_cnt/period_cnt shall hold the last value until the next valid; 0 after reset.
REQ-020 Counters saturate: if p reaches 2^BITS-1 in ARM, HIGH or LOW, set timeout=1, go to ARM, no valid issued; level reflects s.
REQ-021 timeout shall clear on the next valid, or when en=0.
REQ-022 en=0 in any state: go to IDLE next cycle, discard the partial period, keep high_cnt/period_cnt, no valid.
REQ-023 Rise and saturation in the same cycle: rise wins (valid issued, timeout not set).
REQ-024 Minimum measurable: period 2, high 1; a 1-cycle high pulse (rise then fall next cycle) shall be measured as h=1.
REQ-025 0 % and 100 % duty: no edges, so timeout with level=0 or level=1 respectively.

Reset
REQ-026 rstn low: FSM=IDLE, all synchronizer flops and s_d=0, p=h=0, high_cnt=period_cnt=0, valid=0, timeout=0, level=0.
REQ-027 Reset mid-period discards the partial period; after release the first valid requires a fresh ARM rise plus one full period.
REQ-028 No output shall glitch during reset deassertion; deassertion is synchronized externally.

Structure
REQ-029 Shared package pwm_pkg: FSM state typedef (IDLE/ARM/HIGH/LOW) and a default BITS constant, shared with the PWM generator.
REQ-030 One sub-module sync_edge_det: SYNC_STAGES synchronizer + delay flop, outputs s, rise, fall.
REQ-031 Counters, FSM and output registers live in pwm_capture.

Verification
REQ-032 Input 3 high / 7 low repeating, BITS=16 -> after the first full period, valid every 10 cycles with high_cnt=3, period_cnt=10.
REQ-033 Drive from the PWM generator with BITS=4, duty=5, TIMER_DELAY=1 -> high_cnt/period_cnt ratio matches 5/16 of the generator period.
REQ-034 pwm_in held 0, BITS=4 -> timeout=1 after 15 cycles in ARM, level=0, no valid; then start 2/2 toggling -> timeout clears at the next valid, high_cnt=2, period_cnt=4.
REQ-035 1-high/1-low toggling -> high_cnt=1, period_cnt=2, valid every 2 cycles.
REQ-036 en dropped mid-HIGH then restored -> no valid for the partial period, prior outputs held, new valid one full period after the next ARM rise.
REQ-037 rstn asserted mid-LOW -> all outputs 0 immediately; after release the first valid is delayed per REQ-027.
